serial_adder_nbit: RTL and testbench
====================================

# serial_adder_nbit

Multi-cycle, parametrised two's-complement adder that processes a WIDTH-bit operand pair DIGIT bits per clock through a ripple chain of full-adder cells. It carries the carry between digits in a register and reports sum, carry-out and signed overflow with a start/done handshake. It is the sequential successor to the 4-bit combinational adder: one clocked block that trades latency for area and sits between operand registers and the result bus.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits added per clock; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- cin  in  1  carry-in, captured on accepted start.
- sub  in  1  subtract request, captured on accepted start; ignored unless SUBTRACT_EN.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; held until the next accepted start.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 loads the A/B shift registers, loads carry_reg=cin, clears the digit counter and goes to RUN. start=0 stays in IDLE.
- RUN: each cycle the digit adder adds A[DIGIT-1:0], B[DIGIT-1:0] and carry_reg.
  - The digit result shifts into the sum register from the top. A and B shift right by DIGIT.
  - carry_reg takes the digit carry-out and the counter increments.
  - After step N-1, cout and ovf are latched from the final digit and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE (back-to-back, FSM goes to RUN).
  - Otherwise the FSM goes to IDLE.
- start while in RUN is ignored; captured operands are not disturbed.
- sum, cout and ovf change only at the end of an operation. They are not updated during RUN; the internal shift register is separate from the sum output.
- Widths: all arithmetic is modulo 2^WIDTH. No sign extension is performed.
- DIGIT = WIDTH: a single RUN cycle (N = 1), still a legal configuration.

## Timing
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0; counter, carry_reg and shift registers are cleared.
- Reset mid-operation aborts the operation with no done pulse. The first start is accepted on the first edge with rst_n=1.
- Latency, counting the edge that accepts start as edge 0:
  - busy=1 after edge 0 through edge N.
  - done=1 and the result is valid after edge N+1.
  - Edge N+1 may itself accept the next start.
- Throughput: one result every N+1 cycles with back-to-back starts.
- Operands a, b, cin and sub need to be stable only at the accepting edge.

## Configuration
- SUBTRACT_EN defined:
  - sub=1 computes A − B: B is inverted at capture, the initial carry is forced to 1 and cin is ignored.
  - cout=1 means no borrow.
  - ovf uses the same MSB carry rule.
- SUBTRACT_EN undefined:
  - The sub port remains but is ignored; the block always computes A + B + cin.
  - No inversion logic is synthesised.

## Structure
- Package adder_pkg: state enum (IDLE, RUN, DONE) and a counter-width function clog2-based on WIDTH/DIGIT.
- Sub-module digit_adder, parametrised by DIGIT:
  - A purely combinational ripple chain of full-adder cells.
  - Outputs: DIGIT-bit sum, carry-out, and carry into its top bit (for ovf).
- The top level holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=16, DIGIT=4; a=0x1234, b=0x4321, cin=0 → done 5 cycles after the accepting edge; sum=0x5555, cout=0, ovf=0; busy high exactly 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- SUBTRACT_EN defined: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Undefined, same stimulus → sum=0x000D, cout=0.
- start pulsed during RUN with different a/b → ignored; the result equals the first operation's; there is exactly one done pulse.
- rst_n=0 on the 2nd RUN cycle → next cycle busy=0, done=0, sum=0; no done pulse follows.
- start held high in the DONE cycle → new operation accepted; the second done comes N+1 cycles later with the correct sum.
- WIDTH=8, DIGIT=8: a=0x80, b=0x80 → done 2 cycles after start; sum=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder_nbit_pkg.sv
// serial_adder_nbit_pkg: FSM state type and digit-counter width helper for serial_adder_nbit
package serial_adder_nbit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_nbit_digit_adder.sv
// serial_adder_nbit_digit_adder: combinational DIGIT-bit ripple of full adders, exposes carry into top bit
module serial_adder_nbit_digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);
  logic [DIGIT:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar k = 0; k < DIGIT; k++) begin : g_fa
    assign o_sum[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k+1]   = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
  end
  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];
endmodule

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: digit-serial WIDTH-bit adder (DIGIT bits/clk), start/done handshake, SUBTRACT_EN enables A-B via i_sub
module serial_adder_nbit
  import serial_adder_nbit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  state_t                 r_state;
  logic [WIDTH-1:0]       r_a, r_b, r_acc;
  logic                   r_carry;
  logic [CW-1:0]          r_cnt;
  logic [DIGIT-1:0]       w_dsum;
  logic                   w_dcout, w_cmsb, w_accept, w_c_in;
  logic [WIDTH-1:0]       w_b_in;
  logic [WIDTH+DIGIT-1:0] w_cat;
`ifdef SUBTRACT_EN
  assign w_b_in = i_sub ? ~i_b : i_b;
  assign w_c_in = i_sub | i_cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = i_sub;
  assign w_b_in = i_b;
  assign w_c_in = i_cin;
`endif
  assign w_accept = i_start && (r_state == IDLE || r_state == DONE);
  assign w_cat    = {w_dsum, r_acc};
  serial_adder_nbit_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dcout),
    .o_cmsb (w_cmsb)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_done <= r_state == DONE;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= w_b_in;
        r_carry <= w_c_in;
        r_cnt   <= '0;
        r_state <= RUN;
        o_busy  <= 1'b1;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_acc   <= w_cat[WIDTH+DIGIT-1:DIGIT];
        r_carry <= w_dcout;
        r_cnt   <= r_cnt + CW'(1);
        if (r_cnt == CW'(N - 1)) begin
          r_state <= DONE;
          o_busy  <= 1'b0;
          o_sum   <= w_cat[WIDTH+DIGIT-1:DIGIT];
          o_cout  <= w_dcout;
          o_ovf   <= w_cmsb ^ w_dcout;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb_serial_adder_nbit: table-driven and sequence checks of serial_adder_nbit (16/4 and 8/8 instances)
module tb_serial_adder_nbit;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, start, cin, sub;
  logic [15:0] a, b, sum;
  logic        busy, done, cout, ovf;
  logic        start8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, cout8, ovf8;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout), .o_ovf(ovf)
  );
  serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8), .i_cin(1'b0), .i_sub(1'b0),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                       output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
      else if (busy) bcnt++;
    end
  endtask
  vec_t vecs[7];
  int   lat, bcnt, ndone;
  logic [15:0] first_sum;
  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
`ifdef SUBTRACT_EN
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
`else
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0};
`endif
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset16", {busy, done, sum, cout, ovf}, 32'h0);
    chk("reset8", {busy8, done8, sum8, cout8, ovf8}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, bcnt);
      chk($sformatf("lat%0d", i), lat, 5);
      chk($sformatf("busy%0d", i), bcnt, 4);
      chk($sformatf("res%0d", i), {sum, cout, ovf}, {vecs[i].s, vecs[i].co, vecs[i].ov});
    end
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    first_sum = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (ndone == 0) first_sum = sum;
        ndone++;
      end
    end
    chk("ignore_sum", first_sum, 16'h3333);
    chk("ignore_ndone", ndone, 1);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", {busy, done, sum}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_first", {done, busy, sum}, {1'b1, 1'b1, 16'h0003});
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
    chk("b2b_lat", lat, 5);
    chk("b2b_sum", {sum, cout, ovf}, {16'h1000, 1'b0, 1'b0});
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("w8_busy", busy8, 1'b1);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done8) lat = k;
    end
    chk("w8_lat", lat, 2);
    chk("w8_res", {sum8, cout8, ovf8}, {8'h00, 1'b1, 1'b1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
